led_switch_pio: RTL and testbench



---
 rtl/led_switch_pio_pkg.sv | 21 ++
 rtl/sw_debounce.sv | 43 ++++
 rtl/led_switch_pio.sv | 141 ++++++++++++++
 tb/tb_led_switch_pio.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_switch_pio_pkg.sv
// Shared constants and types for the LED/switch PIO: register addresses, LED modes, PWM width.
package led_switch_pio_pkg;

  localparam logic [2:0] ADDR_LED_DATA  = 3'd0;
  localparam logic [2:0] ADDR_LED_MODE  = 3'd1;
  localparam logic [2:0] ADDR_PWM_DUTY  = 3'd2;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd3;
  localparam logic [2:0] ADDR_SW_STATE  = 3'd4;
  localparam logic [2:0] ADDR_SW_EDGE   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd6;

  localparam int unsigned PWM_W = 8;

  typedef enum logic [1:0] {
    MODE_STATIC    = 2'b00,
    MODE_BLINK     = 2'b01,
    MODE_PWM       = 2'b10,
    MODE_BLINK_INV = 2'b11
  } led_mode_e;

endpackage

// File: rtl/sw_debounce.sv
// Single switch input: two-flop synchroniser followed by a stable-count debouncer.
// sw_toggle pulses in the cycle whose clock edge flips sw_state.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_async,
  output logic sw_state,
  output logic sw_toggle
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q, state_q;
  logic [CntW-1:0] cnt_q;

  assign sw_toggle = (sync2_q != state_q) && (cnt_q == CntLast);
  assign sw_state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_async;
      sync2_q <= sync1_q;
      // Any agreement with the accepted state restarts the stability window.
      if (sync2_q == state_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        cnt_q   <= '0;
        state_q <= ~state_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/led_switch_pio.sv
// Avalon-MM LED/switch PIO: per-LED static/blink/PWM modes, debounced switches with edge capture.
// Define LEDPIO_IRQ_EN to build the IRQ_MASK register and the irq output.
module led_switch_pio
  import led_switch_pio_pkg::*;
#(
  parameter int unsigned N_LEDS          = 8,
  parameter int unsigned N_SW            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned BLINK_DIV_RESET = 25000000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [N_LEDS-1:0] led_export,
  input  logic [N_SW-1:0]   switch_export,
  output logic              irq
);

  logic [N_LEDS-1:0]   led_data_q, led_q, led_d;
  logic [2*N_LEDS-1:0] led_mode_q;
  logic [PWM_W-1:0]    pwm_duty_q, pwm_cnt_q;
  logic [31:0]         blink_div_q, presc_q, presc_last;
  logic                blink_phase_q, pwm_on;
  logic [N_SW-1:0]     sw_state, sw_toggle, sw_edge_q, sw_edge_d, sw_clr, irq_mask_rd;
  logic [31:0]         readdata_q, rdata_d;
  logic                wr_led_data, wr_led_mode, wr_pwm_duty, wr_blink_div, wr_sw_edge;

  assign wr_led_data  = avs_write && (avs_address == ADDR_LED_DATA);
  assign wr_led_mode  = avs_write && (avs_address == ADDR_LED_MODE);
  assign wr_pwm_duty  = avs_write && (avs_address == ADDR_PWM_DUTY);
  assign wr_blink_div = avs_write && (avs_address == ADDR_BLINK_DIV);
  assign wr_sw_edge   = avs_write && (avs_address == ADDR_SW_EDGE);

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .sw_async (switch_export[g]),
      .sw_state (sw_state[g]),
      .sw_toggle(sw_toggle[g])
    );
  end

  // A fresh edge overrides a coincident write-1-to-clear.
  assign sw_clr    = wr_sw_edge ? avs_writedata[N_SW-1:0] : '0;
  assign sw_edge_d = (sw_edge_q & ~sw_clr) | sw_toggle;

  // A divider of 0 behaves as 1, i.e. toggle every cycle.
  assign presc_last = (blink_div_q == 32'd0) ? 32'd0 : blink_div_q - 32'd1;
  assign pwm_on     = pwm_cnt_q < pwm_duty_q;

  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      unique case (led_mode_e'(led_mode_q[2*i +: 2]))
        MODE_STATIC:    led_d[i] = led_data_q[i];
        MODE_BLINK:     led_d[i] = led_data_q[i] & blink_phase_q;
        MODE_PWM:       led_d[i] = led_data_q[i] & pwm_on;
        MODE_BLINK_INV: led_d[i] = led_data_q[i] & ~blink_phase_q;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (avs_address)
      ADDR_LED_DATA:  rdata_d[N_LEDS-1:0]   = led_data_q;
      ADDR_LED_MODE:  rdata_d[2*N_LEDS-1:0] = led_mode_q;
      ADDR_PWM_DUTY:  rdata_d[PWM_W-1:0]    = pwm_duty_q;
      ADDR_BLINK_DIV: rdata_d               = blink_div_q;
      ADDR_SW_STATE:  rdata_d[N_SW-1:0]     = sw_state;
      ADDR_SW_EDGE:   rdata_d[N_SW-1:0]     = sw_edge_q;
      ADDR_IRQ_MASK:  rdata_d[N_SW-1:0]     = irq_mask_rd;
      default:        rdata_d               = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      led_data_q    <= '0;
      led_mode_q    <= '0;
      pwm_duty_q    <= 8'h80;
      blink_div_q   <= 32'(BLINK_DIV_RESET);
      presc_q       <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      sw_edge_q     <= '0;
      led_q         <= '0;
      readdata_q    <= '0;
    end else begin
      if (wr_led_data)  led_data_q  <= avs_writedata[N_LEDS-1:0];
      if (wr_led_mode)  led_mode_q  <= avs_writedata[2*N_LEDS-1:0];
      if (wr_pwm_duty)  pwm_duty_q  <= avs_writedata[PWM_W-1:0];
      if (wr_blink_div) blink_div_q <= avs_writedata;
      // Reprogramming the divider restarts the prescaler but keeps the current phase.
      if (wr_blink_div) begin
        presc_q <= '0;
      end else if (presc_q >= presc_last) begin
        presc_q       <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        presc_q <= presc_q + 32'd1;
      end
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      sw_edge_q <= sw_edge_d;
      led_q     <= led_d;
      if (avs_read) readdata_q <= rdata_d;
    end
  end

`ifdef LEDPIO_IRQ_EN
  logic [N_SW-1:0] irq_mask_q;
  logic            irq_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (avs_write && (avs_address == ADDR_IRQ_MASK)) irq_mask_q <= avs_writedata[N_SW-1:0];
      irq_q <= |(sw_edge_q & irq_mask_q);
    end
  end

  assign irq_mask_rd = irq_mask_q;
  assign irq         = irq_q;
`else
  assign irq_mask_rd = '0;
  assign irq         = 1'b0;
`endif

  assign led_export   = led_q;
  assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_led_switch_pio.sv
// Directed self-checking bench for led_switch_pio (DEBOUNCE_CYCLES=8, BLINK_DIV_RESET=100).
module tb_led_switch_pio;
  import led_switch_pio_pkg::*;

  localparam int unsigned NLeds = 8;
  localparam int unsigned NSw   = 4;
`ifdef LEDPIO_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       avs_address;
  logic             avs_read, avs_write;
  logic [31:0]      avs_writedata, avs_readdata;
  logic [NLeds-1:0] led_export;
  logic [NSw-1:0]   switch_export;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_switch_pio #(
    .N_LEDS(NLeds), .N_SW(NSw), .DEBOUNCE_CYCLES(8), .BLINK_DIV_RESET(100)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .led_export   (led_export),
    .switch_export(switch_export),
    .irq          (irq)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    n_cmp++; if (led_export !== 8'h00) begin n_err++;
      $display("FAIL reset_led: got %h want 00", led_export); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (avs_readdata !== 32'h0) begin n_err++;
      $display("FAIL reset_rdata: got %h want 0", avs_readdata); end
    bus_read(ADDR_PWM_DUTY, d);
    n_cmp++; if (d !== 32'h80) begin n_err++; $display("FAIL reset_pwm: got %h want 80", d); end
    bus_read(ADDR_BLINK_DIV, d);
    n_cmp++; if (d !== 32'd100) begin n_err++; $display("FAIL reset_div: got %h want 64", d); end
    bus_read(ADDR_LED_MODE, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mode: got %h want 0", d); end
    bus_read(ADDR_SW_EDGE, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_edge: got %h want 0", d); end
  endtask

  task automatic test_bus;
    logic [31:0] d;
    bus_write(ADDR_LED_DATA, 32'h1FF);
    bus_read(ADDR_LED_DATA, d);
    n_cmp++; if (d !== 32'hFF) begin n_err++; $display("FAIL led_data_rw: got %h want ff", d); end
    bus_write(ADDR_BLINK_DIV, 32'hDEADBEEF);
    bus_read(ADDR_BLINK_DIV, d);
    n_cmp++; if (d !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL blink_div_rw: got %h want deadbeef", d); end
    bus_write(3'd7, 32'hFFFFFFFF);
    bus_read(3'd7, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL addr7: got %h want 0", d); end
    bus_write(ADDR_LED_MODE, 32'hFFFFFFFF);
    @(negedge clk);
    avs_address = ADDR_LED_MODE; avs_read = 1'b1;
    #1;
    n_cmp++; if (avs_readdata !== 32'h0) begin n_err++;
      $display("FAIL mode_early: got %h want 0", avs_readdata); end
    @(negedge clk);
    avs_read = 1'b0;
    n_cmp++; if (avs_readdata !== 32'h0000FFFF) begin n_err++;
      $display("FAIL mode_rd: got %h want 0000ffff", avs_readdata); end
    avs_address = ADDR_SW_STATE;
    @(negedge clk);
    n_cmp++; if (avs_readdata !== 32'h0000FFFF) begin n_err++;
      $display("FAIL rdata_hold: got %h want 0000ffff", avs_readdata); end
    bus_write(ADDR_LED_MODE, 32'h0);
    bus_write(ADDR_LED_DATA, 32'h0);
  endtask

  task automatic test_debounce;
    logic [31:0] d;
    @(negedge clk);
    switch_export[0] = 1'b1;
    repeat (5) @(negedge clk);
    switch_export[0] = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(ADDR_SW_STATE, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL glitch_state: got %h want 0", d); end
    bus_read(ADDR_SW_EDGE, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL glitch_edge: got %h want 0", d); end
    // Read held open: readdata after edge k shows the state as it was after edge k-1.
    @(negedge clk);
    avs_address = ADDR_SW_STATE; avs_read = 1'b1; switch_export[0] = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (avs_readdata !== 32'h0) begin n_err++;
      $display("FAIL deb_early: got %h want 0", avs_readdata); end
    @(negedge clk);
    n_cmp++; if (avs_readdata !== 32'h1) begin n_err++;
      $display("FAIL deb_latency: got %h want 1", avs_readdata); end
    avs_read = 1'b0;
    bus_read(ADDR_SW_EDGE, d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL deb_edge: got %h want 1", d); end
  endtask

  task automatic test_edge_irq;
    logic [31:0] d;
    bus_write(ADDR_IRQ_MASK, 32'h1);
    @(negedge clk);
    n_cmp++; if (irq !== IrqEn) begin n_err++; $display("FAIL irq_set: got %b want %b", irq, IrqEn); end
    bus_read(ADDR_IRQ_MASK, d);
    n_cmp++; if (d !== {31'b0, IrqEn}) begin n_err++;
      $display("FAIL irq_mask_rd: got %h want %h", d, {31'b0, IrqEn}); end
    bus_write(ADDR_SW_EDGE, 32'h1);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clr: got %b want 0", irq); end
    bus_read(ADDR_SW_EDGE, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c: got %h want 0", d); end
    // Falling switch flips the debounced state on edge 10; W1C lands on that same edge.
    @(negedge clk);
    switch_export[0] = 1'b0;
    repeat (9) @(negedge clk);
    avs_address = ADDR_SW_EDGE; avs_writedata = 32'h1; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    bus_read(ADDR_SW_EDGE, d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL set_wins: got %h want 1", d); end
    bus_read(ADDR_SW_STATE, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL fall_state: got %h want 0", d); end
    n_cmp++; if (irq !== IrqEn) begin n_err++;
      $display("FAIL irq_refire: got %b want %b", irq, IrqEn); end
    bus_write(ADDR_SW_EDGE, 32'hF);
    bus_write(ADDR_IRQ_MASK, 32'h0);
  endtask

  task automatic test_pwm;
    int on, other;
    logic [7:0] duty [3];
    int         want [3];
    duty[0] = 8'd64; duty[1] = 8'd0; duty[2] = 8'd255;
    want[0] = 64;    want[1] = 0;    want[2] = 255;
    bus_write(ADDR_LED_DATA, 32'h01);
    bus_write(ADDR_LED_MODE, 32'h2);
    for (int t = 0; t < 3; t++) begin
      bus_write(ADDR_PWM_DUTY, {24'h0, duty[t]});
      repeat (3) @(negedge clk);
      on = 0; other = 0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (led_export[0]) on++;
        if (led_export[7:1] != 7'h0) other++;
      end
      n_cmp++; if (on !== want[t]) begin n_err++;
        $display("FAIL pwm_duty%0d: got %0d want %0d on-cycles", duty[t], on, want[t]); end
      n_cmp++; if (other !== 0) begin n_err++;
        $display("FAIL pwm_others%0d: got %0d want 0", duty[t], other); end
    end
  endtask

  task automatic test_blink;
    logic prev;
    int   trans, same;
    logic [31:0] div [2];
    int          want [2];
    div[0] = 32'd4; div[1] = 32'd0;
    want[0] = 4;    want[1] = 16;
    bus_write(ADDR_LED_DATA, 32'h3);
    bus_write(ADDR_LED_MODE, 32'h0D);
    for (int t = 0; t < 2; t++) begin
      bus_write(ADDR_BLINK_DIV, div[t]);
      repeat (3) @(negedge clk);
      prev = led_export[0]; trans = 0; same = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (led_export[0] != prev) trans++;
        if (led_export[0] == led_export[1]) same++;
        prev = led_export[0];
      end
      n_cmp++; if (trans !== want[t]) begin n_err++;
        $display("FAIL blink_div%0d: got %0d want %0d toggles", div[t], trans, want[t]); end
      n_cmp++; if (same !== 0) begin n_err++;
        $display("FAIL blink_anti%0d: got %0d want 0 in-phase", div[t], same); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bus_write(ADDR_LED_MODE, 32'h0);
    bus_write(ADDR_LED_DATA, 32'hFF);
    @(negedge clk);
    n_cmp++; if (led_export !== 8'hFF) begin n_err++;
      $display("FAIL static_on: got %h want ff", led_export); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (led_export !== 8'h00) begin n_err++;
      $display("FAIL async_rst_led: got %h want 00", led_export); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(ADDR_PWM_DUTY, d);
    n_cmp++; if (d !== 32'h80) begin n_err++; $display("FAIL mid_pwm: got %h want 80", d); end
    bus_read(ADDR_BLINK_DIV, d);
    n_cmp++; if (d !== 32'd100) begin n_err++; $display("FAIL mid_div: got %h want 64", d); end
    bus_read(ADDR_LED_DATA, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_data: got %h want 0", d); end
  endtask

  initial begin
    rst_n = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    switch_export = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_bus();
    test_debounce();
    test_edge_irq();
    test_pwm();
    test_blink();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
